// File: rtl/serial_ext_link.sv
// serial_ext_link: external-clock (responder) end of the link port.
// Decodes SB (FF01) and SC (FF02), shifts 8 bits MSB-first on the partner's
// SCK, and requests the serial interrupt when a byte completes.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   a, din, rd, wr    CPU bus (dout is combinational from a)
//   dout              read data
//   int_serial_req    serial interrupt request (registered)
//   int_serial_ack    interrupt acknowledge
//   sck_in, sin       partner clock / data (asynchronous)
//   sout              serial data to partner (registered)
module serial_ext_link #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  input  logic        rd,
  input  logic        wr,
  output logic        int_serial_req,
  input  logic        int_serial_ack,
  input  logic        sck_in,
  input  logic        sin,
  output logic        sout
);

  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state, state_n;
  logic [7:0]           sb, sb_n;
  logic                 sc_start, sc_start_n;
  logic                 sc_int, sc_int_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [TW-1:0]        timer, timer_n;
  logic                 req_n, sout_n, set_req;
  logic [SYNC_STAGES-1:0] sck_sync, sin_sync;
  logic                 sck_prev, sck_s, sin_s, rise, fall;
  logic                 sb_wr, sc_wr;
  logic                 unused_rd;

  // Reads have no side effects, so the strobe is not needed.
  assign unused_rd = rd;

  // Matched synchronizers keep sin aligned with sck.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '1;
      sin_sync <= '1;
      sck_prev <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      sin_sync <= {sin_sync[SYNC_STAGES-2:0], sin};
      sck_prev <= sck_s;
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sin_s = sin_sync[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_prev;
  assign fall  = ~sck_s & sck_prev;
  assign sb_wr = wr && (a == ADDR_SB);
  assign sc_wr = wr && (a == ADDR_SC);

  // Read decode.
  always_comb begin
    dout = 8'hFF;
    if (a == ADDR_SB)      dout = sb;
    else if (a == ADDR_SC) dout = {sc_start, 6'b111111, sc_int};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sb             <= 8'h00;
      sc_start       <= 1'b0;
      sc_int         <= 1'b0;
      bit_cnt        <= 3'd0;
      timer          <= '0;
      int_serial_req <= 1'b0;
      sout           <= 1'b1;
    end else begin
      state          <= state_n;
      sb             <= sb_n;
      sc_start       <= sc_start_n;
      sc_int         <= sc_int_n;
      bit_cnt        <= bit_cnt_n;
      timer          <= timer_n;
      int_serial_req <= req_n;
      sout           <= sout_n;
    end
  end

  // Next state; bus writes take priority and swallow a coincident SCK edge.
  always_comb begin
    state_n    = state;
    sb_n       = sb;
    sc_start_n = sc_start;
    sc_int_n   = sc_int;
    bit_cnt_n  = bit_cnt;
    timer_n    = timer;
    sout_n     = sout;
    set_req    = 1'b0;

    if (sc_wr) begin
      sc_start_n = din[7];
      sc_int_n   = din[0];
      bit_cnt_n  = 3'd0;
      timer_n    = '0;
      if (din[7] && !din[0]) begin
        state_n = ACTIVE;
        sout_n  = sb[7];
      end else begin
        state_n = IDLE;
      end
    end else if (sb_wr) begin
      if (state == IDLE) sb_n = din;
    end else if (state == ACTIVE) begin
      if (rise) begin
        sb_n      = {sb[6:0], sin_s};
        bit_cnt_n = bit_cnt + 3'd1;
        timer_n   = '0;
        if (bit_cnt == 3'd7) begin
          sc_start_n = 1'b0;
          set_req    = 1'b1;
          state_n    = IDLE;
        end
      end else if (fall) begin
        sout_n  = sb[7];
        timer_n = '0;
      end else if (TIMEOUT != 0) begin
        // Partner stalled: abandon the byte without interrupting.
        if (timer == TW'(TIMEOUT - 1)) begin
          sc_start_n = 1'b0;
          bit_cnt_n  = 3'd0;
          state_n    = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
    end

    // A new completion wins over a same-cycle acknowledge.
    req_n = (int_serial_req & ~int_serial_ack) | set_req;
  end

endmodule

// File: tb/tb_serial_ext_link.sv
// Directed bench for serial_ext_link (SYNC_STAGES=2, TIMEOUT=1000).
module tb_serial_ext_link;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        rd;
  logic        wr;
  logic        int_serial_req;
  logic        int_serial_ack;
  logic        sck_in;
  logic        sin;
  logic        sout;

  int n_cmp = 0;
  int n_err = 0;

  serial_ext_link #(.SYNC_STAGES(2), .TIMEOUT(1000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a              (a),
    .dout           (dout),
    .din            (din),
    .rd             (rd),
    .wr             (wr),
    .int_serial_req (int_serial_req),
    .int_serial_ack (int_serial_ack),
    .sck_in         (sck_in),
    .sin            (sin),
    .sout           (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [15:0] addr, input logic [7:0] exp, input string tag);
    a  = addr;
    rd = 1'b1;
    #1;
    chk(tag, dout, exp);
    rd = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] d);
    @(negedge clk);
    a   = addr;
    din = d;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
    a   = 16'h0000;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    int_serial_ack = 1'b1;
    @(negedge clk);
    int_serial_ack = 1'b0;
  endtask

  // One SCK period: 64 clk low then 64 clk high; sout sampled mid-low.
  task automatic sck_period(input logic b, input logic exp_so, input logic chk_en, input string tag);
    @(negedge clk);
    sck_in = 1'b0;
    sin    = b;
    repeat (32) @(negedge clk);
    if (chk_en) chk(tag, {7'd0, sout}, {7'd0, exp_so});
    repeat (32) @(negedge clk);
    sck_in = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  // Shift bits hi..lo of data_in, checking sout against sb0 bits.
  task automatic send_bits(input logic [7:0] data_in, input logic [7:0] sb0,
                           input int hi, input int lo, input string tag);
    for (int i = hi; i >= lo; i--) sck_period(data_in[i], sb0[i], 1'b1, tag);
  endtask

  initial begin
    rst_n = 1'b0; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
    int_serial_ack = 1'b0; sck_in = 1'b1; sin = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 reset values
    rd_chk(16'hFF02, 8'h7E, "t1_sc");
    rd_chk(16'hFF01, 8'h00, "t1_sb");
    rd_chk(16'h1234, 8'hFF, "t1_unmapped");
    chk("t1_sout", {7'd0, sout}, 8'h01);
    chk("t1_req", {7'd0, int_serial_req}, 8'h00);

    // T2 basic transfer
    bus_wr(16'hFF01, 8'hA5);
    bus_wr(16'hFF02, 8'h80);
    rd_chk(16'hFF02, 8'hFE, "t2_sc_active");
    send_bits(8'h3C, 8'hA5, 7, 0, "t2_sout");
    rd_chk(16'hFF01, 8'h3C, "t2_sb");
    rd_chk(16'hFF02, 8'h7E, "t2_sc_done");
    chk("t2_req", {7'd0, int_serial_req}, 8'h01);
    ack_pulse();
    chk("t2_req_ack", {7'd0, int_serial_req}, 8'h00);

    // T3 abort after 3 rises
    bus_wr(16'hFF01, 8'hA5);
    bus_wr(16'hFF02, 8'h80);
    send_bits(8'h3C, 8'hA5, 7, 5, "t3_sout");
    bus_wr(16'hFF02, 8'h00);
    rd_chk(16'hFF01, 8'h29, "t3_sb_partial");
    rd_chk(16'hFF02, 8'h7E, "t3_sc");
    chk("t3_req", {7'd0, int_serial_req}, 8'h00);
    sck_period(1'b1, 1'b0, 1'b0, "t3_idle");
    sck_period(1'b0, 1'b0, 1'b0, "t3_idle");
    rd_chk(16'hFF01, 8'h29, "t3_sb_frozen");

    // T4 timeout after 4 rises, then a fresh transfer
    bus_wr(16'hFF01, 8'hA5);
    bus_wr(16'hFF02, 8'h80);
    send_bits(8'h3C, 8'hA5, 7, 4, "t4_sout");
    rd_chk(16'hFF02, 8'hFE, "t4_still_active");
    repeat (1000) @(negedge clk);
    rd_chk(16'hFF02, 8'h7E, "t4_timed_out");
    chk("t4_req", {7'd0, int_serial_req}, 8'h00);
    bus_wr(16'hFF01, 8'hA5);
    bus_wr(16'hFF02, 8'h80);
    send_bits(8'h96, 8'hA5, 7, 0, "t4_sout2");
    rd_chk(16'hFF01, 8'h96, "t4_sb2");
    chk("t4_req2", {7'd0, int_serial_req}, 8'h01);
    ack_pulse();

    // T5 internal-clock request is not acted on
    bus_wr(16'hFF02, 8'h81);
    rd_chk(16'hFF02, 8'hFF, "t5_sc");
    for (int i = 0; i < 8; i++) sck_period(i[0], 1'b0, 1'b0, "t5_idle");
    rd_chk(16'hFF02, 8'hFF, "t5_sc_after");
    rd_chk(16'hFF01, 8'h96, "t5_sb");
    chk("t5_req", {7'd0, int_serial_req}, 8'h00);
    bus_wr(16'hFF01, 8'h5A);
    rd_chk(16'hFF01, 8'h5A, "t5_sb_wr");

    // T6 collisions
    bus_wr(16'hFF01, 8'hA5);
    bus_wr(16'hFF02, 8'h80);
    send_bits(8'hC0, 8'hA5, 7, 6, "t6_sout");
    bus_wr(16'hFF01, 8'h00);
    rd_chk(16'hFF01, 8'h97, "t6_sb_wr_ignored");
    // SC write lands on the cycle the rise is acted upon.
    @(negedge clk);
    sck_in = 1'b0;
    sin    = 1'b0;
    repeat (64) @(negedge clk);
    sck_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a = 16'hFF02; din = 8'h80; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; a = 16'h0000;
    repeat (62) @(negedge clk);
    rd_chk(16'hFF01, 8'h97, "t6_bit_dropped");
    rd_chk(16'hFF02, 8'hFE, "t6_restarted");
    send_bits(8'hC3, 8'h97, 7, 0, "t6_sout2");
    rd_chk(16'hFF01, 8'hC3, "t6_sb2");
    chk("t6_req", {7'd0, int_serial_req}, 8'h01);

    // T6 async reset mid-transfer (req still pending)
    bus_wr(16'hFF02, 8'h80);
    send_bits(8'h00, 8'hC3, 7, 3, "t6_sout3");
    rd_chk(16'hFF01, 8'h60, "t6_sb_pre_rst");
    chk("t6_sout_pre_rst", {7'd0, sout}, 8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    rd_chk(16'hFF02, 8'h7E, "t6_rst_sc");
    rd_chk(16'hFF01, 8'h00, "t6_rst_sb");
    chk("t6_rst_sout", {7'd0, sout}, 8'h01);
    chk("t6_rst_req", {7'd0, int_serial_req}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
